// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch front end.
package mips_fetch_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned FETCH_ENTRY_W = 64;
    localparam int unsigned FIFO_CNT_W    = 2;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_EXC_VECTOR = 32'h0000_0080;

    // Fetch FSM state encoding
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry skid buffer holding fetched {instr, pc} pairs; head is a register.
module fetch_skid_fifo
    import mips_fetch_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  push,
    input  fetch_entry_t          push_data,
    input  logic                  pop,
    output logic [FIFO_CNT_W-1:0] count,
    output fetch_entry_t          head
);

    fetch_entry_t tail;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else if (clear) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == FIFO_CNT_W'(0)) head <= push_data;
                    else                         tail <= push_data;
                    count <= count + FIFO_CNT_W'(1);
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - FIFO_CNT_W'(1);
                end
                2'b11: begin
                    // Occupancy unchanged; the new entry lands behind whatever remains
                    if (count == FIFO_CNT_W'(1)) begin
                        head <= push_data;
                    end else begin
                        head <= tail;
                        tail <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && count == FIFO_CNT_W'(0)));
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && count == FIFO_CNT_W'(2)));

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, issues one imem read per cycle and
// buffers responses for decode, handling redirects, exceptions and halt.
module fetch_sequencer
    import mips_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter logic [XLEN-1:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_en,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            exc_req,
    input  logic            halt_req,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic            halted
);

    logic [0:0]            state;
    logic [0:0]            next_state;
    logic [XLEN-1:0]       fetch_pc;
    logic [XLEN-1:0]       next_pc;
    logic                  inflight;
    logic [XLEN-1:0]       inflight_pc;
    logic                  issue;
    logic                  flush;
    logic                  pop;
    logic                  push;
    logic [2:0]            occupancy;
    logic [FIFO_CNT_W-1:0] count;
    fetch_entry_t          head;
    fetch_entry_t          push_data;

    // State, PC and in-flight tracking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            state    <= next_state;
            fetch_pc <= next_pc;
            inflight <= issue;
            if (issue) inflight_pc <= fetch_pc;
        end
    end

    // Next-state, issue decision and PC update
    always_comb begin
        next_state = state;
        next_pc    = fetch_pc;
        issue      = 1'b0;
        pop        = out_valid && out_ready;
        flush      = exc_req || redirect_valid;
        push       = inflight && !flush;
        occupancy  = 3'(count) + 3'(inflight) - 3'(pop);

        case (state)
            ST_RUN: begin
                issue = rst_n && !halt_req && !flush && (occupancy < 3'd2);
                if (halt_req && !inflight) next_state = ST_HALT;
            end
            ST_HALT: begin
                if (!halt_req) next_state = ST_RUN;
            end
            default: next_state = ST_RUN;
        endcase

        // Exception takes priority over a simultaneous redirect
        if (exc_req)             next_pc = EXC_VECTOR;
        else if (redirect_valid) next_pc = word_align(redirect_pc);
        else if (issue)          next_pc = fetch_pc + XLEN'(4);
    end

    assign push_data = '{instr: imem_rdata, pc: inflight_pc};

    fetch_skid_fifo u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .count     (count),
        .head      (head)
    );

    assign imem_en   = issue;
    assign imem_addr = fetch_pc;
    assign out_valid = (count != FIFO_CNT_W'(0));
    assign out_instr = head.instr;
    assign out_pc    = head.pc;
    assign halted    = (state == ST_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed table-driven bench for fetch_sequencer with a word-index memory model.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        exc_req;
    logic        halt_req;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;

    int checks = 0;
    int errors = 0;

    fetch_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .exc_req        (exc_req),
        .halt_req       (halt_req),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: word at byte address a holds a/4
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= imem_addr >> 2;
    end

    typedef struct {
        logic        rst;
        logic        ready;
        logic        halt;
        logic        redir;
        logic        exc;
        logic [31:0] rpc;
        logic        ev;
        logic        chk;
        logic [31:0] epc;
        logic        en;
        logic [31:0] addr;
        logic        hlt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic ready, input logic halt,
                       input logic redir, input logic exc, input logic [31:0] rpc,
                       input logic ev, input logic chk, input logic [31:0] epc,
                       input logic en, input logic [31:0] addr, input logic hlt);
        vec_t v;
        v.rst = rst; v.ready = ready; v.halt = halt; v.redir = redir; v.exc = exc;
        v.rpc = rpc; v.ev = ev; v.chk = chk; v.epc = epc; v.en = en; v.addr = addr;
        v.hlt = hlt;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (step %0d): got %h expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; out_ready = 1'b1; halt_req = 1'b0;
        redirect_valid = 1'b0; exc_req = 1'b0; redirect_pc = '0;

        //   rst rdy hlt red exc rpc        ev chk epc        en addr       halted
        add(1, 1, 0, 0, 0, 32'h0,   0, 1, 32'h0,   1, 32'h0,   0); // cycle 0
        add(1, 1, 0, 0, 0, 32'h0,   0, 0, 32'h0,   1, 32'h4,   0);
        add(1, 1, 0, 0, 0, 32'h0,   1, 1, 32'h0,   1, 32'h8,   0);
        add(1, 1, 0, 0, 0, 32'h0,   1, 1, 32'h4,   1, 32'hc,   0);
        for (int i = 0; i < 5; i++)
            add(1, 0, 0, 0, 0, 32'h0, 1, 1, 32'h8, 0, 32'h10, 0);  // stall at pc 8
        add(1, 1, 0, 0, 0, 32'h0,   1, 1, 32'h8,   1, 32'h10,  0);
        add(1, 1, 0, 0, 0, 32'h0,   1, 1, 32'hc,   1, 32'h14,  0);
        add(1, 1, 0, 0, 0, 32'h0,   1, 1, 32'h10,  1, 32'h18,  0);
        add(1, 1, 0, 0, 0, 32'h0,   1, 1, 32'h14,  1, 32'h1c,  0);
        add(1, 0, 0, 0, 0, 32'h0,   1, 1, 32'h18,  0, 32'h20,  0);
        add(1, 0, 0, 1, 0, 32'h43,  1, 1, 32'h18,  0, 32'h20,  0); // redirect, FIFO full
        add(1, 1, 0, 0, 0, 32'h0,   0, 0, 32'h0,   1, 32'h40,  0);
        add(1, 1, 0, 0, 0, 32'h0,   0, 0, 32'h0,   1, 32'h44,  0);
        add(1, 1, 0, 0, 0, 32'h0,   1, 1, 32'h40,  1, 32'h48,  0);
        add(1, 1, 0, 0, 0, 32'h0,   1, 1, 32'h44,  1, 32'h4c,  0);
        add(1, 1, 0, 1, 1, 32'h200, 1, 1, 32'h48,  0, 32'h50,  0); // exc beats redirect
        add(1, 1, 0, 0, 0, 32'h0,   0, 0, 32'h0,   1, 32'h80,  0);
        add(1, 1, 0, 0, 0, 32'h0,   0, 0, 32'h0,   1, 32'h84,  0);
        add(1, 1, 0, 0, 0, 32'h0,   1, 1, 32'h80,  1, 32'h88,  0);
        add(1, 1, 0, 0, 0, 32'h0,   1, 1, 32'h84,  1, 32'h8c,  0);
        add(1, 1, 1, 0, 0, 32'h0,   1, 1, 32'h88,  0, 32'h90,  0); // halt window
        add(1, 1, 1, 0, 0, 32'h0,   1, 1, 32'h8c,  0, 32'h90,  0);
        add(1, 1, 1, 0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h90,  1);
        add(1, 1, 1, 0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h90,  1);
        add(1, 1, 0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h90,  1);
        add(1, 1, 0, 0, 0, 32'h0,   0, 0, 32'h0,   1, 32'h90,  0);
        add(1, 1, 0, 0, 0, 32'h0,   0, 0, 32'h0,   1, 32'h94,  0);
        add(1, 1, 0, 0, 0, 32'h0,   1, 1, 32'h90,  1, 32'h98,  0);
        add(1, 0, 0, 0, 0, 32'h0,   1, 1, 32'h94,  0, 32'h9c,  0);
        add(1, 0, 0, 0, 0, 32'h0,   1, 1, 32'h94,  0, 32'h9c,  0);
        add(0, 0, 0, 0, 0, 32'h0,   1, 1, 32'h94,  0, 32'h9c,  0); // reset, full FIFO
        add(1, 1, 0, 0, 0, 32'h0,   0, 1, 32'h0,   1, 32'h0,   0);
        add(1, 1, 0, 0, 0, 32'h0,   0, 0, 32'h0,   1, 32'h4,   0);
        add(1, 1, 0, 0, 0, 32'h0,   1, 1, 32'h0,   1, 32'h8,   0);
        add(1, 1, 0, 0, 0, 32'h0,   1, 1, 32'h4,   1, 32'hc,   0);

        // Values held during reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_out_valid", -1, 32'(out_valid), 32'h0);
        check("rst_out_pc",    -1, out_pc,         32'h0);
        check("rst_out_instr", -1, out_instr,      32'h0);
        check("rst_imem_en",   -1, 32'(imem_en),   32'h0);
        check("rst_imem_addr", -1, imem_addr,      32'h0);
        check("rst_halted",    -1, 32'(halted),    32'h0);

        foreach (vecs[i]) begin
            rst_n          = vecs[i].rst;
            out_ready      = vecs[i].ready;
            halt_req       = vecs[i].halt;
            redirect_valid = vecs[i].redir;
            exc_req        = vecs[i].exc;
            redirect_pc    = vecs[i].rpc;
            #1;
            check("out_valid", i, 32'(out_valid), 32'(vecs[i].ev));
            if (vecs[i].chk) begin
                check("out_pc",    i, out_pc,    vecs[i].epc);
                check("out_instr", i, out_instr, vecs[i].epc >> 2);
            end
            check("imem_en",   i, 32'(imem_en), 32'(vecs[i].en));
            check("imem_addr", i, imem_addr,    vecs[i].addr);
            check("halted",    i, 32'(halted),  32'(vecs[i].hlt));
            @(negedge clk);
        end
        redirect_valid = 1'b0; exc_req = 1'b0;

        // Flush while halted with entries buffered, then resume at target
        begin
            bit seen;
            out_ready = 1'b0;
            halt_req  = 1'b1;
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                #1;
                if (halted) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("halt_reached", 100, 32'(seen), 32'h1);
            check("halt_buffered_valid", 100, 32'(out_valid), 32'h1);
            check("halt_no_issue", 100, 32'(imem_en), 32'h0);
            redirect_valid = 1'b1;
            redirect_pc    = 32'h107;
            @(negedge clk);
            redirect_valid = 1'b0;
            #1;
            check("halt_flush_valid",  101, 32'(out_valid), 32'h0);
            check("halt_flush_addr",   101, imem_addr,      32'h104);
            check("halt_flush_halted", 101, 32'(halted),    32'h1);
            halt_req  = 1'b0;
            out_ready = 1'b1;
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                #1;
                if (out_valid) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("resume_valid", 102, 32'(seen),  32'h1);
            check("resume_pc",    102, out_pc,     32'h104);
            check("resume_instr", 102, out_instr,  32'h41);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
